// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU side (fetch path, load/store buffer, RAM/IO) and mem_arbiter.
//   clear_in                        : ROB misprediction flush
//   if_valid/if_addr                : fetch request, held until if_done
//   if_done/if_data                 : fetch completion pulse and little-endian word
//   lsb_valid/lsb_wr/lsb_size/
//   lsb_addr/lsb_wdata              : load/store request, held until lsb_done
//   lsb_done/lsb_rdata              : load/store completion pulse and zero-extended data
//   mem_din/mem_dout/mem_a/mem_wr   : byte-wide RAM/IO bus
//   io_buffer_full                  : UART TX back-pressure
// slave is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  logic        clear_in;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_valid;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  clear_in, if_valid, if_addr, lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output clear_in, if_valid, if_addr, lsb_valid, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, lsb_done, lsb_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction word fetches and 1/2/4-byte loads/stores
// onto a byte-wide RAM/IO bus, round-robin between fetch and load/store buffer.
//   clk_in : clock
//   rst_in : asynchronous active-high reset
//   bus    : request/response and RAM/IO signals (see mem_arbiter_if)
// Reads are aborted by clear_in; stores always complete. Stores whose base address is in IO
// space stall while io_buffer_full is high. All outputs are registered.
module mem_arbiter #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input logic          clk_in,
  input logic          rst_in,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  len_q, len_d;
  // Read: edges elapsed since grant. Write: index of the next byte to issue.
  logic [2:0]  cnt_q, cnt_d;
  logic        is_lsb_q, is_lsb_d;
  logic        last_lsb_q, last_lsb_d;

  logic        if_done_q, if_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;

  logic        grant_if, grant_lsb;
  logic [2:0]  lsb_len;
  logic [2:0]  rd_idx;
  logic [31:0] rd_word;
  logic        io_stall;

  // Size 3 is illegal; it is treated as a word access.
  assign lsb_len = (bus.lsb_size == 2'd0) ? 3'd1 :
                   (bus.lsb_size == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    grant_if  = 1'b0;
    grant_lsb = 1'b0;
    if (state_q == StIdle && !bus.clear_in) begin
      if (bus.lsb_valid && (!bus.if_valid || !last_lsb_q)) begin
        grant_lsb = 1'b1;
      end else if (bus.if_valid) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    is_lsb_d    = is_lsb_q;
    last_lsb_d  = last_lsb_q;
    if_done_d   = 1'b0;
    if_data_d   = if_data_q;
    lsb_done_d  = 1'b0;
    lsb_rdata_d = lsb_rdata_q;
    mem_a_d     = '0;
    mem_dout_d  = '0;
    mem_wr_d    = 1'b0;
    io_stall    = (addr_q >= IO_BASE) && bus.io_buffer_full;
    // The byte arriving now was addressed two edges after grant earlier than cnt_q.
    rd_idx      = cnt_q - 3'd2;
    rd_word     = buf_q;
    rd_word[{rd_idx[1:0], 3'b000} +: 8] = bus.mem_din;

    unique case (state_q)
      StIdle: begin
        if (grant_if || grant_lsb) begin
          last_lsb_d = grant_lsb;
          is_lsb_d   = grant_lsb;
          addr_d     = grant_lsb ? bus.lsb_addr : bus.if_addr;
          wdata_d    = bus.lsb_wdata;
          len_d      = grant_lsb ? lsb_len : 3'd4;
          buf_d      = '0;
          mem_a_d    = addr_d;
          if (grant_lsb && bus.lsb_wr) begin
            state_d    = StWrite;
            mem_dout_d = bus.lsb_wdata[7:0];
            if ((bus.lsb_addr >= IO_BASE) && bus.io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              cnt_d    = 3'd1;
              mem_wr_d = 1'b1;
            end
          end else begin
            state_d = StRead;
            cnt_d   = 3'd1;
          end
        end
      end

      StRead: begin
        if (bus.clear_in) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < len_q) begin
            mem_a_d = addr_q + 32'(cnt_q);
          end
          if (cnt_q >= 3'd2) begin
            buf_d = rd_word;
            if (rd_idx == len_q - 3'd1) begin
              state_d = StDone;
              if (is_lsb_q) begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = rd_word;
              end else begin
                if_done_d = 1'b1;
                if_data_d = rd_word;
              end
            end
          end
        end
      end

      StWrite: begin
        if (cnt_q == len_q) begin
          lsb_done_d = 1'b1;
          state_d    = StDone;
        end else begin
          mem_a_d    = addr_q + 32'(cnt_q);
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = !io_stall;
          if (!io_stall) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      is_lsb_q    <= 1'b0;
      last_lsb_q  <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      is_lsb_q    <= is_lsb_d;
      last_lsb_q  <= last_lsb_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a byte RAM model drives mem_din, a reference memory and
// transaction-level latency rules predict done timing, read data and the store byte trace.
module tb_mem_arbiter;
  localparam logic [31:0] IoBase = 32'h30000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.IO_BASE(IoBase)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM seen by the DUT (synchronous read, one cycle latency) and the reference memory.
  logic [7:0]  ram     [65536];
  logic [7:0]  ref_mem [65536];
  logic        poke_en = 1'b0;
  logic [15:0] poke_a  = '0;
  logic [7:0]  poke_d  = '0;

  function automatic logic [7:0] dflt(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3c;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem[a[15:0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 65536; i++) ram[16'(i)] <= dflt(16'(i));
    end else if (poke_en) begin
      ram[poke_a] <= poke_d;
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[15:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[15:0]];
  end

  logic [39:0] wr_log [$];
  always @(negedge clk) if (bus.mem_wr) wr_log.push_back({bus.mem_a, bus.mem_dout});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1;
    poke_a  = a[15:0];
    poke_d  = d;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a[15:0]] = d;
  endtask

  // One transaction from an idle arbiter. io_buffer_full is high for the first `stall` edges
  // from grant; clear_in is pulsed at edge grant+clr_at (negative: never).
  task automatic run_single(input bit is_if, input bit wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                            input int clr_at, input string tag);
    int          n, g, d, exp_lat, base, other;
    bit          seen, is_st;
    logic [31:0] exp_data, got_data, a;
    is_st    = wr && !is_if;
    n        = is_if ? 4 : (1 << size);
    exp_lat  = is_st ? (n + ((addr >= IoBase) ? stall : 0)) : (n + 1);
    exp_data = '0;
    for (int k = 0; k < n; k++) begin
      if (!is_st) exp_data[8*k +: 8] = ref_rd(addr + 32'(k));
    end
    base = wr_log.size();
    @(negedge clk);
    if (is_if) begin
      bus.if_valid = 1'b1;
      bus.if_addr  = addr;
    end else begin
      bus.lsb_valid = 1'b1;
      bus.lsb_wr    = wr;
      bus.lsb_size  = size;
      bus.lsb_addr  = addr;
      bus.lsb_wdata = wdata;
    end
    g = cyc + 1;
    seen = 1'b0; other = 0; d = 0; got_data = '0;
    bus.io_buffer_full = (cyc + 1 - g < stall);
    bus.clear_in       = (cyc + 1 - g == clr_at);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      bus.io_buffer_full = (cyc + 1 - g < stall);
      bus.clear_in       = (cyc + 1 - g == clr_at);
      if (is_if ? bus.if_done : bus.lsb_done) begin
        seen     = 1'b1;
        d        = cyc;
        got_data = is_if ? bus.if_data : bus.lsb_rdata;
      end
      if (is_if ? bus.lsb_done : bus.if_done) other++;
    end
    bus.if_valid = 1'b0;
    bus.lsb_valid = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.clear_in = 1'b0;
    check_eq({tag, " done seen"}, 64'(seen), 64'd1);
    check_eq({tag, " latency"}, 64'(d - g), 64'(exp_lat));
    check_eq({tag, " other done"}, 64'(other), 64'd0);
    if (is_st) begin
      check_eq({tag, " write count"}, 64'(wr_log.size() - base), 64'(n));
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        if (base + k < wr_log.size()) begin
          check_eq({tag, " write byte"}, 64'(wr_log[base + k]), 64'({a, wdata[8*k +: 8]}));
        end
        ref_mem[a[15:0]] = wdata[8*k +: 8];
      end
    end else begin
      check_eq({tag, " data"}, 64'(got_data), 64'(exp_data));
      check_eq({tag, " write count"}, 64'(wr_log.size() - base), 64'd0);
    end
    @(negedge clk);
  endtask

  task automatic req_if(input logic [31:0] a, output int dcyc);
    int t;
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_addr  = a;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.if_done && t < 100);
    dcyc = bus.if_done ? cyc : -1;
    bus.if_valid = 1'b0;
  endtask

  task automatic req_ld(input logic [1:0] sz, input logic [31:0] a, output int dcyc);
    int t;
    @(negedge clk);
    bus.lsb_valid = 1'b1;
    bus.lsb_wr    = 1'b0;
    bus.lsb_size  = sz;
    bus.lsb_addr  = a;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.lsb_done && t < 100);
    dcyc = bus.lsb_done ? cyc : -1;
    bus.lsb_valid = 1'b0;
  endtask

  int ic [2];
  int lc [2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int          g, d, other, c0, e0, e1, e2, e3, kind;
    bit          seen;
    logic [1:0]  s0, s1, sz;
    logic [31:0] got, exp, a;

    for (int i = 0; i < 65536; i++) ref_mem[16'(i)] = dflt(16'(i));
    bus.clear_in = 1'b0; bus.if_valid = 1'b0; bus.if_addr = '0;
    bus.lsb_valid = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_size = '0;
    bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.io_buffer_full = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("reset if_done", 64'(bus.if_done), 64'd0);
    check_eq("reset if_data", 64'(bus.if_data), 64'd0);
    check_eq("reset lsb_done", 64'(bus.lsb_done), 64'd0);
    check_eq("reset lsb_rdata", 64'(bus.lsb_rdata), 64'd0);
    check_eq("reset mem_a", 64'(bus.mem_a), 64'd0);
    check_eq("reset mem_dout", 64'(bus.mem_dout), 64'd0);
    check_eq("reset mem_wr", 64'(bus.mem_wr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Both requesters continuously valid right after reset: LSB, IF, LSB, IF.
    s0 = 2'($urandom_range(0, 2));
    s1 = 2'($urandom_range(0, 2));
    c0 = cyc;
    fork
      begin
        req_if(32'h0000_0500, ic[0]);
        req_if(32'h0000_0600, ic[1]);
      end
      begin
        req_ld(s0, 32'h0000_0700, lc[0]);
        req_ld(s1, 32'h0000_0800, lc[1]);
      end
    join
    e0 = c0 + 2 + (1 << s0) + 1;
    e1 = e0 + 2 + 5;
    e2 = e1 + 2 + (1 << s1) + 1;
    e3 = e2 + 2 + 5;
    check_eq("rr lsb0 done", 64'(lc[0]), 64'(e0));
    check_eq("rr if0 done", 64'(ic[0]), 64'(e1));
    check_eq("rr lsb1 done", 64'(lc[1]), 64'(e2));
    check_eq("rr if1 done", 64'(ic[1]), 64'(e3));
    @(negedge clk);

    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    run_single(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, -1, "if word");
    poke(32'h2002, 8'hFE); poke(32'h2003, 8'hFF);
    run_single(1'b0, 1'b0, 2'd1, 32'h2002, 32'h0, 0, -1, "half load");
    run_single(1'b0, 1'b1, 2'd2, 32'h1000, 32'hDEAD_BEEF, 0, -1, "word store");
    run_single(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 0, -1, "word readback");
    run_single(1'b0, 1'b1, 2'd0, 32'h30000, 32'h0000_005A, 3, -1, "io store stall");
    run_single(1'b0, 1'b1, 2'd2, 32'h1200, 32'h1234_5678, 3, -1, "ram store io full");
    run_single(1'b0, 1'b1, 2'd2, 32'h1400, $urandom, 0, 2, "clear store");

    // clear two cycles into an IF read, with a load pending behind it.
    @(negedge clk);
    bus.if_valid = 1'b1;
    bus.if_addr  = 32'h200;
    g = cyc + 1;
    @(negedge clk);
    bus.lsb_valid = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_size = 2'd2; bus.lsb_addr = 32'h240;
    @(negedge clk);
    bus.clear_in = 1'b1;
    bus.if_valid = 1'b0;
    @(negedge clk);
    bus.clear_in = 1'b0;
    check_eq("clear read mem_a", 64'(bus.mem_a), 64'd0);
    seen = 1'b0; other = 0; d = 0; got = '0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.if_done) other++;
      if (bus.lsb_done) begin
        seen = 1'b1;
        d    = cyc;
        got  = bus.lsb_rdata;
      end
    end
    bus.lsb_valid = 1'b0;
    check_eq("clear read no if_done", 64'(other), 64'd0);
    check_eq("clear read lsb latency", 64'(d - g), 64'd8);
    exp = {ref_rd(32'h243), ref_rd(32'h242), ref_rd(32'h241), ref_rd(32'h240)};
    check_eq("clear read lsb data", 64'(got), 64'(exp));
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = IoBase - 32'd2 + 32'($urandom_range(0, 4));
        2:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      run_single(kind == 0, kind == 2, sz, a, $urandom, int'($urandom_range(0, 3)), -1,
                 $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a store.
    @(negedge clk);
    bus.lsb_valid = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_size = 2'd2;
    bus.lsb_addr = 32'h7000; bus.lsb_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid write mem_wr", 64'(bus.mem_wr), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid reset mem_wr", 64'(bus.mem_wr), 64'd0);
    check_eq("mid reset mem_a", 64'(bus.mem_a), 64'd0);
    check_eq("mid reset mem_dout", 64'(bus.mem_dout), 64'd0);
    check_eq("mid reset lsb_done", 64'(bus.lsb_done), 64'd0);
    bus.lsb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
